regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (RegWrite / Write_Reg_Num / Write_Data) between two writeback requesters.
  - Requester A: ALU result path.
  - Requester B: load/memory return path.
- Round-robin arbitration with valid/ready handshakes.
- Registered write stage feeding the register file.
- Exposes a read-after-write hazard flag for the decode stage.

Parameters:
- DATA_W, 8, width of write data.
- ADDR_W, 3, width of register number (2**ADDR_W registers).
- FIRST_PRIO, 0, requester winning the first tie after reset (0=A, 1=B).

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Hold  input  1  when 1, no grants are issued (pipeline freeze).
- A_Valid  input  1  requester A has a write pending.
- A_Reg  input  ADDR_W  destination register for A.
- A_Data  input  DATA_W  write data for A.
- A_Ready  output  1  A transfer accepted this cycle.
- B_Valid  input  1  requester B has a write pending.
- B_Reg  input  ADDR_W  destination register for B.
- B_Data  input  DATA_W  write data for B.
- B_Ready  output  1  B transfer accepted this cycle.
- RegWrite  output  1  write strobe to the register file.
- Write_Reg_Num  output  ADDR_W  register-file write address.
- Write_Data  output  DATA_W  register-file write data.
- Read_Reg_Num  input  ADDR_W  register currently being read by decode.
- Read_Hazard  output  1  read targets the register being written this cycle.
- Last_Grant  output  1  requester granted most recently (0=A, 1=B).

Behaviour:
- Reset (async, any time):
  - RegWrite=0, Write_Reg_Num=0, Write_Data=0.
  - Last_Grant = ~FIRST_PRIO, so the FIRST_PRIO requester wins the first tie.
  - Any accepted-but-uncommitted write is dropped.
  - A_Ready/B_Ready are 0 while Reset=1.
- Handshake:
  - Transfer occurs when X_Valid && X_Ready.
  - X_Ready is combinational from the current Valids, Hold and Last_Grant.
  - A requester keeps Valid, Reg and Data stable until its Ready is seen.
- Arbitration (per cycle, Hold=0):
  - Neither valid: no grant.
  - Exactly one valid: grant it.
  - Both valid: grant the requester != Last_Grant.
  - At most one Ready is high per cycle.
- Hold=1: both Readys are 0, Last_Grant is unchanged, and the write stage still drains.
- Last_Grant updates to the granted requester on each transfer; otherwise it holds.
- Write stage: the cycle after a transfer:
  - RegWrite=1.
  - Write_Reg_Num and Write_Data equal the transferred Reg and Data.
  - The register file commits on that edge.
  - Latency: 1 cycle from handshake to RegWrite.
- Without a transfer, RegWrite=0 and Write_Reg_Num/Write_Data hold their previous values.
- The write stage never back-pressures: the register file accepts one write per cycle, so throughput is 1 write/cycle.
- Back-to-back writes from the same requester are allowed when the other requester is idle.
- Same destination from A and B in consecutive grants: both commit in grant order; the later one wins.
- Read_Hazard = RegWrite && (Write_Reg_Num == Read_Reg_Num).
  - Combinational.
  - Flags that the register-file read value is stale this cycle.
- Fairness: with both requesters continuously valid, grants alternate A,B,A,B; maximum wait is 1 cycle.

Optional Feature:
- Macro RWA_BYPASS_EN.
- Defined:
  - Adds output Fwd_Data [DATA_W-1:0], which equals Write_Data whenever Read_Hazard=1, else 0.
  - Decode selects Fwd_Data over the register-file read data when Read_Hazard=1.
- Not defined:
  - The Fwd_Data port is absent.
  - Read_Hazard is still produced; decode must stall one cycle on it.

Test Plan:
- Reset asserted mid-cycle while A transfer of r3=0x55 in flight -> RegWrite drops to 0 immediately, no commit, Last_Grant=1 (FIRST_PRIO=0).
- A_Valid only, A_Reg=2, A_Data=0x7E -> A_Ready=1 same cycle; next cycle RegWrite=1, Write_Reg_Num=2, Write_Data=0x7E.
- A and B both valid continuously for 4 cycles after reset (A: r1=0x11, B: r4=0x44) -> grants A,B,A,B; RegWrite high 4 consecutive cycles with alternating addresses 1,4,1,4.
- Hold=1 for 3 cycles with both valid -> A_Ready=B_Ready=0, RegWrite=0 after the drain cycle; Hold released -> grant order resumes from the unchanged Last_Grant.
- A writes r5=0x9C, B writes r5=0x03 next grant -> commits 0x9C then 0x03; final r5=0x03.
- Read_Reg_Num=5 while RegWrite=1, Write_Reg_Num=5 -> Read_Hazard=1; with RWA_BYPASS_EN, Fwd_Data=Write_Data; with Read_Reg_Num=6 -> Read_Hazard=0, Fwd_Data=0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the register-file write port between the ALU (A) and load (B) writeback paths; 1-cycle handshake-to-RegWrite.
// Write stage never back-pressures; Hold freezes grants only. Optional forwarding output under `RWA_BYPASS_EN.
module regfile_write_arbiter #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Hold,
  input  logic              A_Valid,
  input  logic [ADDR_W-1:0] A_Reg,
  input  logic [DATA_W-1:0] A_Data,
  output logic              A_Ready,
  input  logic              B_Valid,
  input  logic [ADDR_W-1:0] B_Reg,
  input  logic [DATA_W-1:0] B_Data,
  output logic              B_Ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] Write_Reg_Num,
  output logic [DATA_W-1:0] Write_Data,
  input  logic [ADDR_W-1:0] Read_Reg_Num,
  output logic              Read_Hazard,
`ifdef RWA_BYPASS_EN
  output logic [DATA_W-1:0] Fwd_Data,
`endif
  output logic              Last_Grant
);

  // Reset to the opposite requester so FIRST_PRIO wins the first tie.
  localparam logic LG_RST = !FIRST_PRIO;

  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] wr_num_q, wr_num_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              last_grant_q, last_grant_d;
  logic              a_ready, b_ready;

  always_comb begin
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    reg_write_d  = 1'b0;
    wr_num_d     = wr_num_q;
    wr_data_d    = wr_data_q;
    last_grant_d = last_grant_q;

    if (!Reset && !Hold) begin
      if (A_Valid && (!B_Valid || last_grant_q)) begin
        a_ready = 1'b1;
      end else if (B_Valid) begin
        b_ready = 1'b1;
      end
    end

    if (a_ready) begin
      reg_write_d  = 1'b1;
      wr_num_d     = A_Reg;
      wr_data_d    = A_Data;
      last_grant_d = 1'b0;
    end else if (b_ready) begin
      reg_write_d  = 1'b1;
      wr_num_d     = B_Reg;
      wr_data_d    = B_Data;
      last_grant_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      reg_write_q  <= 1'b0;
      wr_num_q     <= '0;
      wr_data_q    <= '0;
      last_grant_q <= LG_RST;
    end else begin
      reg_write_q  <= reg_write_d;
      wr_num_q     <= wr_num_d;
      wr_data_q    <= wr_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign A_Ready       = a_ready;
  assign B_Ready       = b_ready;
  assign RegWrite      = reg_write_q;
  assign Write_Reg_Num = wr_num_q;
  assign Write_Data    = wr_data_q;
  assign Last_Grant    = last_grant_q;
  // Register file sees the old value while a write to the same register is in the write stage.
  assign Read_Hazard   = reg_write_q && (wr_num_q == Read_Reg_Num);

`ifdef RWA_BYPASS_EN
  assign Fwd_Data = Read_Hazard ? wr_data_q : '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: per-cycle vector table plus a write scoreboard, and reset corner sequences.
module tb_regfile_write_arbiter;

  logic       Clk = 1'b0;
  logic       Reset, Hold;
  logic       A_Valid, B_Valid, A_Ready, B_Ready;
  logic [2:0] A_Reg, B_Reg, Write_Reg_Num, Read_Reg_Num;
  logic [7:0] A_Data, B_Data, Write_Data;
  logic       RegWrite, Read_Hazard, Last_Grant;
`ifdef RWA_BYPASS_EN
  logic [7:0] Fwd_Data;
`endif

  regfile_write_arbiter #(.DATA_W(8), .ADDR_W(3), .FIRST_PRIO(1'b0)) dut (
    .Clk(Clk), .Reset(Reset), .Hold(Hold),
    .A_Valid(A_Valid), .A_Reg(A_Reg), .A_Data(A_Data), .A_Ready(A_Ready),
    .B_Valid(B_Valid), .B_Reg(B_Reg), .B_Data(B_Data), .B_Ready(B_Ready),
    .RegWrite(RegWrite), .Write_Reg_Num(Write_Reg_Num), .Write_Data(Write_Data),
    .Read_Reg_Num(Read_Reg_Num), .Read_Hazard(Read_Hazard),
`ifdef RWA_BYPASS_EN
    .Fwd_Data(Fwd_Data),
`endif
    .Last_Grant(Last_Grant)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic hold, av; logic [2:0] ar; logic [7:0] ad;
    logic bv; logic [2:0] br; logic [7:0] bd; logic [2:0] rr;
    logic ea, eb, ewr, ehz;
  } vec_t;

  typedef struct { logic [2:0] num; logic [7:0] dat; } wr_t;

  vec_t vecs [24];
  wr_t  sbq [$];
  wr_t  last_wr, exp_wr;
  logic [7:0] rf_dut [8];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(logic hold, logic av, logic [2:0] ar, logic [7:0] ad,
                              logic bv, logic [2:0] br, logic [7:0] bd, logic [2:0] rr,
                              logic ea, logic eb, logic ewr, logic ehz);
    vec_t v;
    v.hold = hold; v.av = av; v.ar = ar; v.ad = ad;
    v.bv = bv; v.br = br; v.bd = bd; v.rr = rr;
    v.ea = ea; v.eb = eb; v.ewr = ewr; v.ehz = ehz;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(vec_t v);
    Hold = v.hold; A_Valid = v.av; A_Reg = v.ar; A_Data = v.ad;
    B_Valid = v.bv; B_Reg = v.br; B_Data = v.bd; Read_Reg_Num = v.rr;
  endtask

  initial begin
    //             hold av ar  ad     bv br  bd     rr   ea eb wr hz
    vecs[0]  = mk(0, 1, 1, 8'h11, 1, 4, 8'h44, 1,  1, 0, 0, 0);
    vecs[1]  = mk(0, 1, 1, 8'h11, 1, 4, 8'h44, 1,  0, 1, 1, 1);
    vecs[2]  = mk(0, 1, 1, 8'h11, 1, 4, 8'h44, 1,  1, 0, 1, 0);
    vecs[3]  = mk(0, 1, 1, 8'h11, 1, 4, 8'h44, 1,  0, 1, 1, 1);
    vecs[4]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 4,  0, 0, 1, 1);
    vecs[5]  = mk(0, 1, 2, 8'h7E, 0, 0, 8'h00, 0,  1, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 2,  0, 0, 1, 1);
    vecs[7]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 2,  0, 0, 0, 0);
    vecs[8]  = mk(0, 1, 1, 8'h11, 1, 4, 8'h44, 0,  0, 1, 0, 0);
    vecs[9]  = mk(1, 1, 1, 8'h11, 1, 4, 8'h44, 0,  0, 0, 1, 0);
    vecs[10] = mk(1, 1, 1, 8'h11, 1, 4, 8'h44, 0,  0, 0, 0, 0);
    vecs[11] = mk(1, 1, 1, 8'h11, 1, 4, 8'h44, 0,  0, 0, 0, 0);
    vecs[12] = mk(0, 1, 1, 8'h11, 1, 4, 8'h44, 0,  1, 0, 0, 0);
    vecs[13] = mk(0, 1, 1, 8'h11, 1, 4, 8'h44, 0,  0, 1, 1, 0);
    vecs[14] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 1, 0);
    vecs[15] = mk(0, 1, 5, 8'h9C, 0, 0, 8'h00, 0,  1, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 8'h00, 1, 5, 8'h03, 6,  0, 1, 1, 0);
    vecs[17] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 5,  0, 0, 1, 1);
    vecs[18] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 6,  0, 0, 0, 0);
    vecs[19] = mk(0, 1, 6, 8'hA1, 0, 0, 8'h00, 0,  1, 0, 0, 0);
    vecs[20] = mk(0, 1, 7, 8'hB2, 0, 0, 8'h00, 6,  1, 0, 1, 1);
    vecs[21] = mk(0, 0, 0, 8'h00, 1, 0, 8'h5A, 7,  0, 1, 1, 1);
    vecs[22] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 1, 1);
    vecs[23] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 0, 0);

    for (int r = 0; r < 8; r++) rf_dut[r] = 8'h00;
    last_wr = '{num: 3'd0, dat: 8'h00};

    // Reset state, with A requesting to confirm Ready stays low.
    Reset = 1'b1; Hold = 1'b0;
    A_Valid = 1'b1; A_Reg = 3'd1; A_Data = 8'h11;
    B_Valid = 1'b0; B_Reg = 3'd0; B_Data = 8'h00; Read_Reg_Num = 3'd0;
    #12;
    chk("rst_a_ready", A_Ready, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_wr_num", Write_Reg_Num, 0);
    chk("rst_wr_data", Write_Data, 0);
    chk("rst_last_grant", Last_Grant, 1);
    A_Valid = 1'b0;
    #10 Reset = 1'b0;
    @(posedge Clk); #1;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i]);
      #4;
      chk($sformatf("v%0d_a_ready", i), A_Ready, vecs[i].ea);
      chk($sformatf("v%0d_b_ready", i), B_Ready, vecs[i].eb);
      chk($sformatf("v%0d_regwrite", i), RegWrite, vecs[i].ewr);
      chk($sformatf("v%0d_hazard", i), Read_Hazard, vecs[i].ehz);
      if (vecs[i].ewr) begin
        if (sbq.size() == 0) begin
          chk($sformatf("v%0d_sb_empty", i), 1, 0);
        end else begin
          exp_wr = sbq.pop_front();
          chk($sformatf("v%0d_wr_num", i), Write_Reg_Num, exp_wr.num);
          chk($sformatf("v%0d_wr_data", i), Write_Data, exp_wr.dat);
          last_wr = exp_wr;
        end
      end else begin
        chk($sformatf("v%0d_hold_num", i), Write_Reg_Num, last_wr.num);
        chk($sformatf("v%0d_hold_data", i), Write_Data, last_wr.dat);
      end
`ifdef RWA_BYPASS_EN
      chk($sformatf("v%0d_fwd", i), Fwd_Data, vecs[i].ehz ? last_wr.dat : 8'h00);
`endif
      if (RegWrite) rf_dut[Write_Reg_Num] = Write_Data;
      if (vecs[i].ea) sbq.push_back('{num: vecs[i].ar, dat: vecs[i].ad});
      if (vecs[i].eb) sbq.push_back('{num: vecs[i].br, dat: vecs[i].bd});
      @(posedge Clk); #1;
    end
    chk("sb_drained", sbq.size(), 0);
    chk("rf_r5_final", rf_dut[5], 8'h03);
    chk("rf_r0_final", rf_dut[0], 8'h5A);

    // Reset lands while A's r3=0x55 write sits in the write stage.
    Hold = 1'b0; A_Valid = 1'b1; A_Reg = 3'd3; A_Data = 8'h55; B_Valid = 1'b0;
    Read_Reg_Num = 3'd3;
    #4;
    chk("inflight_a_ready", A_Ready, 1);
    @(posedge Clk); #1;
    A_Valid = 1'b0;
    chk("inflight_regwrite", RegWrite, 1);
    chk("inflight_last_grant", Last_Grant, 0);
    Reset = 1'b1;
    #1;
    chk("midrst_regwrite", RegWrite, 0);
    chk("midrst_wr_num", Write_Reg_Num, 0);
    chk("midrst_wr_data", Write_Data, 0);
    chk("midrst_last_grant", Last_Grant, 1);
    chk("midrst_hazard", Read_Hazard, 0);
    A_Valid = 1'b1;
    #1;
    chk("midrst_a_ready", A_Ready, 0);
    #1;
    if (RegWrite) rf_dut[Write_Reg_Num] = Write_Data;
    A_Valid = 1'b0;
    #6 Reset = 1'b0;
    repeat (2) begin
      @(posedge Clk); #1;
      if (RegWrite) rf_dut[Write_Reg_Num] = Write_Data;
      chk("postrst_idle_regwrite", RegWrite, 0);
    end
    chk("rf_r3_not_committed", rf_dut[3], 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
